encoder_seq: RTL



---
 rtl/encoder_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/encoder_seq.sv
// rtl/encoder_seq.sv - sequential priority encoder, emits set-bit indices highest first
//
// Captures a WIDTH-bit request vector on load. It then presents the index of
// each set bit on y, highest index first, one code per valid/ready handshake.
//
// Optional feature macro: ENC_COUNT_EN
//   When defined, this adds the output cnt. cnt holds the number of codes that
//   have not yet been accepted.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous reset, active-high
//   i      in   request vector, sampled only on an accepted load
//   load   in   capture strobe; honoured only while idle
//   y      out  index of the highest pending bit
//   valid  out  y holds a code
//   ready  in   consumer accepts y when valid && ready
//   busy   out  pending vector non-zero
//   done   out  one-cycle pulse after the last code is accepted
//   none   out  one-cycle pulse when a load captured all-zero
//   cnt    out  remaining code count (ENC_COUNT_EN only)

module encoder_seq #(
    parameter int WIDTH  = 8,
    parameter int CODE_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  i,
    input  logic              load,
    output logic [CODE_W-1:0] y,
    output logic              valid,
    input  logic              ready,
    output logic              busy,
    output logic              done,
    output logic              none
`ifdef ENC_COUNT_EN
    ,
    output logic [CODE_W:0]   cnt
`endif
);

    generate
        if (WIDTH < 2 || WIDTH > 64 || (1 << CODE_W) != WIDTH) begin : g_bad_param
            $error("encoder_seq: WIDTH must be a power of two in 2..64 and CODE_W = log2(WIDTH)");
        end
    endgenerate

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pending_q, pending_d;
    logic [CODE_W-1:0]  y_q, y_d;
    logic               done_q, done_d;
    logic               none_q, none_d;
    logic [WIDTH-1:0]   pend_clr;

    // Index of the highest set bit. An all-zero vector yields 0, so y rests
    // at 0 once the vector is empty.
    function automatic logic [CODE_W-1:0] msb_index(input logic [WIDTH-1:0] v);
        logic [CODE_W-1:0] r;
        r = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (v[k]) r = CODE_W'(k);
        end
        return r;
    endfunction

`ifdef ENC_COUNT_EN
    logic [CODE_W:0] cnt_q, cnt_d;

    function automatic logic [CODE_W:0] popcount(input logic [WIDTH-1:0] v);
        logic [CODE_W:0] c;
        c = '0;
        for (int k = 0; k < WIDTH; k++) begin
            c = c + (CODE_W+1)'(v[k]);
        end
        return c;
    endfunction
`endif

    // This is the pending vector with the bit currently shown on y removed.
    assign pend_clr = pending_q & ~(WIDTH'(1) << y_q);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        y_d       = y_q;
        done_d    = 1'b0;
        none_d    = 1'b0;
`ifdef ENC_COUNT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (load) begin
                    pending_d = i;
                    y_d       = msb_index(i);
`ifdef ENC_COUNT_EN
                    cnt_d     = popcount(i);
`endif
                    if (i != '0) state_d = SEND;
                    else         none_d  = 1'b1;
                end
            end
            SEND: begin
                // A load is ignored here. This includes a load in the same
                // cycle as the final accept.
                if (ready) begin
                    pending_d = pend_clr;
                    y_d       = msb_index(pend_clr);
`ifdef ENC_COUNT_EN
                    cnt_d     = cnt_q - 1'b1;
`endif
                    if (pend_clr == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            y_q       <= '0;
            done_q    <= 1'b0;
            none_q    <= 1'b0;
`ifdef ENC_COUNT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            y_q       <= y_d;
            done_q    <= done_d;
            none_q    <= none_d;
`ifdef ENC_COUNT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign y     = y_q;
    assign valid = (state_q == SEND);
    assign busy  = (pending_q != '0);
    assign done  = done_q;
    assign none  = none_q;
`ifdef ENC_COUNT_EN
    assign cnt   = cnt_q;
`endif

endmodule
